// File: rtl/seq_mult_param_if.sv
// Handshake/operand bundle for seq_mult_param; signed_op exists only when MULT_SIGNED_EN is defined.
interface seq_mult_param_if #(
    parameter int L_WORD = 8
);
    logic                  start;
    logic [L_WORD-1:0]     word1;
    logic [L_WORD-1:0]     word2;
    logic [2*L_WORD-1:0]   product;
    logic                  ready;
    logic                  done;
`ifdef MULT_SIGNED_EN
    logic                  signed_op;

    modport master (output start, word1, word2, signed_op, input product, ready, done);
    modport slave  (input  start, word1, word2, signed_op, output product, ready, done);
`else
    modport master (output start, word1, word2, input product, ready, done);
    modport slave  (input  start, word1, word2, output product, ready, done);
`endif
endinterface

// File: rtl/seq_mult_param.sv
// Sequential shift-and-add multiplier with trivial-operand shortcuts.
// Optional two's-complement mode is enabled by defining MULT_SIGNED_EN.
module seq_mult_param #(
    parameter int L_WORD = 8
) (
    input  logic             clock,
    input  logic             reset,
    seq_mult_param_if.slave  bus
);
    localparam int P_W = 2 * L_WORD;

    typedef enum logic [1:0] {IDLE, LOAD, MULT} state_t;

    state_t            state_q, state_d;
    logic [L_WORD-1:0] a_q, a_d;
    logic [L_WORD-1:0] b_q, b_d;
    logic [P_W-1:0]    mcand_q, mcand_d;
    logic [L_WORD-1:0] mplier_q, mplier_d;
    logic [P_W-1:0]    product_q, product_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    logic [L_WORD-1:0] mag1, mag2;
    logic [P_W-1:0]    acc;
    logic [P_W-1:0]    result;
    logic              finish;

`ifdef MULT_SIGNED_EN
    logic neg_q, neg_d;

    // Magnitude of the most negative value still fits, since it is held unsigned.
    always_comb begin
        mag1 = (bus.signed_op && bus.word1[L_WORD-1]) ? (~bus.word1 + L_WORD'(1)) : bus.word1;
        mag2 = (bus.signed_op && bus.word2[L_WORD-1]) ? (~bus.word2 + L_WORD'(1)) : bus.word2;
    end
`else
    assign mag1 = bus.word1;
    assign mag2 = bus.word2;
`endif

    // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        done_d    = done_q;
        ready_d   = ready_q;
`ifdef MULT_SIGNED_EN
        neg_d     = neg_q;
`endif
        finish    = 1'b0;
        result    = '0;
        acc       = product_q + (mplier_q[0] ? mcand_q : '0);

        unique case (state_q)
            IDLE: begin
                // ready rises one edge after reset, so start is only seen once ready_q is set.
                ready_d = 1'b1;
                if (ready_q && bus.start) begin
                    a_d     = mag1;
                    b_d     = mag2;
`ifdef MULT_SIGNED_EN
                    neg_d   = bus.signed_op && (bus.word1[L_WORD-1] ^ bus.word2[L_WORD-1]);
`endif
                    done_d  = 1'b0;
                    ready_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (a_q == '0 || b_q == '0) begin
                    finish = 1'b1;
                    result = '0;
                end else if (a_q == L_WORD'(1)) begin
                    finish = 1'b1;
                    result = P_W'(b_q);
                end else if (b_q == L_WORD'(1)) begin
                    finish = 1'b1;
                    result = P_W'(a_q);
                end else begin
                    mcand_d   = P_W'(a_q);
                    mplier_d  = b_q;
                    product_d = '0;
                    state_d   = MULT;
                end
            end
            MULT: begin
                product_d = acc;
                mplier_d  = mplier_q >> 1;
                mcand_d   = mcand_q << 1;
                if ((mplier_q >> 1) == '0) begin
                    finish = 1'b1;
                    result = acc;
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
`ifdef MULT_SIGNED_EN
            product_d = neg_q ? (~result + P_W'(1)) : result;
`else
            product_d = result;
`endif
            done_d    = 1'b1;
            ready_d   = 1'b1;
            state_d   = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
`ifdef MULT_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign bus.product = product_q;
    assign bus.done    = done_q;
    assign bus.ready   = ready_q;
endmodule
